// File: rtl/maj_odd_voter.sv
// maj_odd_voter: registered N-input majority / odd-parity voter with a
// persistence-filtered majority and a saturating disagreement counter. Rev 1.0
`default_nettype none

module maj_odd_voter #(
   parameter int N     = 3,
   parameter int HOLD  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic [1:0]       out,
   output logic             maj_filt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int POP_W = $clog2(N + 1);
   localparam int RUN_W = $clog2(HOLD + 1);
   localparam logic [POP_W-1:0] C_MAJ_THR = POP_W'((N - 1) / 2);
   localparam logic [POP_W-1:0] C_POP_ALL = POP_W'(N);
   localparam logic [RUN_W-1:0] C_HOLD    = RUN_W'(HOLD);
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               maj_filt_q, maj_filt_d;
   logic [1:0]         out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [POP_W-1:0]   pop;
   logic               maj;
   logic               odd;
   logic               unanimous;
   logic [RUN_W-1:0]   run_inc;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + POP_W'(in_data[i]);
      end
   end

   assign maj       = (pop > C_MAJ_THR);
   assign odd       = pop[0];
   assign unanimous = (pop == '0) || (pop == C_POP_ALL);
   assign run_inc   = run_q + RUN_W'(1);

   // Result register and disagreement counter; clear wins over counting.
   always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (in_valid) begin
         out_d       = {maj, odd};
         out_valid_d = 1'b1;
      end
      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (in_valid && !unanimous && (err_cnt_q != C_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Persistence filter: idle cycles leave state and run untouched.
   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      maj_filt_d = maj_filt_q;
      if (in_valid) begin
         case (state_q)
            ST_STABLE: begin
               if (maj != maj_filt_q) begin
                  if (HOLD == 1) begin
                     maj_filt_d = maj;
                     run_d      = '0;
                  end else begin
                     state_d = ST_PENDING;
                     run_d   = RUN_W'(1);
                  end
               end else begin
                  run_d = '0;
               end
            end
            ST_PENDING: begin
               if (maj == maj_filt_q) begin
                  state_d = ST_STABLE;
                  run_d   = '0;
               end else if (run_inc == C_HOLD) begin
                  maj_filt_d = maj;
                  state_d    = ST_STABLE;
                  run_d      = '0;
               end else begin
                  run_d = run_inc;
               end
            end
            default: begin
               state_d = ST_STABLE;
               run_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_STABLE;
         run_q       <= '0;
         maj_filt_q  <= 1'b0;
         out_q       <= 2'b00;
         out_valid_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         maj_filt_q  <= maj_filt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign maj_filt  = maj_filt_q;
   assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
